layer7_argmax: RTL
==================

Name: layer7_argmax

Overview:
- Classification stage directly downstream of Layer7. Consumes the 7-channel IEEE-754 single-precision score vector and produces the index and value of the largest score.
- Compares one channel per clock: 1 comparator, sequential scan.
- A one-entry pending buffer absorbs a vector that arrives while a scan is in progress. Layer7 has no backpressure.

Parameters:
- DATA_WIDHT, 32, width of one channel word (IEEE-754 single precision only).
- CHANNEL_IN, 7, number of channels per input vector.
- INDEX_WIDTH, 3, width of the class index; must satisfy 2^INDEX_WIDTH >= CHANNEL_IN.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the clk rising edge.
- Data_In  in  DATA_WIDHT*CHANNEL_IN  score vector; channel k = Data_In[32k+31:32k].
- Valid_In  in  1  Data_In is valid this cycle; each high cycle is one vector.
- Class_Out  out  INDEX_WIDTH  index of the maximum channel.
- Max_Out  out  DATA_WIDHT  raw bits of the maximum channel.
- Valid_Out  out  1  one-cycle pulse; Class_Out/Max_Out valid while high.
- Busy  out  1  high while in state SCAN.
- Overflow  out  1  sticky; set when an input vector is dropped.

Behaviour:
- Reset (rst=0 at an edge): state IDLE; Class_Out=0, Max_Out=0, Valid_Out=0, Busy=0, Overflow=0; pending buffer emptied.
  - A scan in flight at reset is abandoned. No Valid_Out is produced for it.
- States: IDLE, SCAN.
- IDLE, Valid_In=1 at edge E0:
  - Capture the vector into the work register.
  - best <= ch0, idx <= 0, cnt <= 1, go to SCAN.
- SCAN, one edge per channel: compare ch[cnt] against best, update best/idx, cnt <= cnt+1.
  - The edge processing ch[CHANNEL_IN-1] is the last scan edge (E6 for default).
  - At that edge: Class_Out/Max_Out <= final result, Valid_Out <= 1 for exactly one cycle.
  - Latency: Valid_Out is high during the cycle after E6, i.e. 6 edges after the capture edge.
  - Class_Out/Max_Out hold their value until the next result.
- Next-state at the last scan edge:
  - Pending buffer full: load it into the work register and start a new scan. The pending buffer empties; Busy stays 1.
  - Else, Valid_In=1 on that same edge: load Data_In directly and start a new scan.
  - Else: go to IDLE.
- Valid_In=1 during SCAN (including the last edge, when the pending buffer is full and is being consumed):
  - If the pending buffer is empty, or is being consumed on this edge: write the vector into the pending buffer.
  - Otherwise: drop the vector and set Overflow=1. Overflow clears only on reset.
- Sustained throughput: one vector per CHANNEL_IN-1 cycles.
- Comparison rule (combinational compare, registered update):
  - Candidate c replaces best iff c is not NaN AND (best is NaN OR c > best).
  - Ties keep the lower index.
  - -0 and +0 compare equal.
  - +inf/-inf are ordered normally.
  - Denormals compare by magnitude; no flushing.
- Float ordering:
  - Both non-negative: unsigned magnitude compare.
  - Both negative: reversed magnitude compare.
  - Mixed signs: the positive value wins, except the +0/-0 case, which is equal.
- All-NaN vector: Class_Out=0, Max_Out=ch0 bits.
- No arithmetic performed; outputs are raw input bits.

Test Plan:
- Single vector after reset:
  - Stimulus: ch0..ch6 = 3F800000, 40000000, BF800000, 3F000000, C0400000, 3F800000, 3FC00000.
  - Required: exactly one Valid_Out pulse, 6 cycles after the capture edge; Class_Out=1, Max_Out=40000000; Busy high 6 cycles.
- Ties and signed zero:
  - Stimulus: all channels BF800000 except ch3=ch5=40400000. Required: Class_Out=3, Max_Out=40400000.
  - Stimulus: ch0=80000000, ch2=00000000, all others C0000000. Required: Class_Out=0, Max_Out=80000000.
- NaN/inf:
  - Stimulus: ch0=7FC00000, ch4=7F800000, others 3F800000. Required: Class_Out=4, Max_Out=7F800000.
  - Stimulus: all channels 7FC00000. Required: Class_Out=0, Max_Out=7FC00000.
- Back-to-back with buffering:
  - Stimulus: vector A at E0, B at E2, C at E6, with results A=2, B=5, C=6.
  - Required: Valid_Out pulses at E0+6, E0+12, E0+18 with classes 2, 5, 6; Overflow stays 0.
- Overflow:
  - Stimulus: Valid_In held high 4 consecutive cycles from IDLE.
  - Required: vectors 1 and 2 processed; vectors 3 and 4 dropped; Overflow=1 from the edge after vector 3 and stays 1; exactly 2 Valid_Out pulses.
- Reset mid-scan:
  - Stimulus: rst=0 for one edge at E0+3.
  - Required: next cycle Busy=0, Valid_Out=0, Class_Out=0, Max_Out=0, Overflow=0; no pulse for the aborted vector; a new vector after reset produces its normal result.

Source files
------------

// File: rtl/layer7_argmax_if.sv
// Score-vector input and argmax result bundle between Layer7 and the argmax stage.
// The master side (Layer7 / bench) drives Data_In/Valid_In; the argmax stage drives the result.
interface layer7_argmax_if #(
  parameter int DATA_WIDHT  = 32,
  parameter int CHANNEL_IN  = 7,
  parameter int INDEX_WIDTH = 3
);
  logic [DATA_WIDHT*CHANNEL_IN-1:0] Data_In;
  logic                             Valid_In;
  logic [INDEX_WIDTH-1:0]           Class_Out;
  logic [DATA_WIDHT-1:0]            Max_Out;
  logic                             Valid_Out;
  logic                             Busy;
  logic                             Overflow;

  modport master (
    output Data_In, Valid_In,
    input  Class_Out, Max_Out, Valid_Out, Busy, Overflow
  );

  modport slave (
    input  Data_In, Valid_In,
    output Class_Out, Max_Out, Valid_Out, Busy, Overflow
  );
endinterface

// File: rtl/layer7_argmax.sv
// Sequential argmax over a Layer7 float32 score vector: one channel compared per clock,
// with a one-entry pending buffer since Layer7 cannot be stalled.
module layer7_argmax #(
  parameter int DATA_WIDHT  = 32,
  parameter int CHANNEL_IN  = 7,
  parameter int INDEX_WIDTH = 3
) (
  input  logic           clk,
  input  logic           rst,
  layer7_argmax_if.slave bus
);
  typedef logic [CHANNEL_IN-1:0][DATA_WIDHT-1:0] vec_t;
  typedef logic [DATA_WIDHT-1:0]                 word_t;
  typedef logic [INDEX_WIDTH-1:0]                idx_t;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;
  localparam idx_t       LAST   = idx_t'(CHANNEL_IN - 1);

  function automatic logic is_nan(input word_t f);
    return (&f[30:23]) && (|f[22:0]);
  endfunction

  // Ordering on raw bits; signed zeros are equal, so +0 does not beat -0.
  function automatic logic fgt(input word_t a, input word_t b);
    logic both_zero;
    both_zero = (a[30:0] == '0) && (b[30:0] == '0);
    case ({a[31], b[31]})
      2'b00:   return a[30:0] > b[30:0];
      2'b11:   return a[30:0] < b[30:0];
      2'b01:   return !both_zero;
      default: return 1'b0;
    endcase
  endfunction

  logic [0:0] state_q, state_d;
  vec_t       work_q, work_d;
  vec_t       pend_q, pend_d;
  logic       pvld_q, pvld_d;
  word_t      best_q, best_d;
  idx_t       idx_q, idx_d;
  idx_t       cnt_q, cnt_d;
  idx_t       cls_q, cls_d;
  word_t      max_q, max_d;
  logic       vout_q, vout_d;
  logic       ovf_q, ovf_d;

  vec_t  din, start_vec;
  word_t cand, best_nx;
  idx_t  idx_nx;
  logic  take, last;

  assign din       = vec_t'(bus.Data_In);
  // A new scan starts from the pending entry if one is waiting, else from the bus.
  assign start_vec = pvld_q ? pend_q : din;
  assign cand      = work_q[cnt_q];
  assign take      = !is_nan(cand) && (is_nan(best_q) || fgt(cand, best_q));
  assign best_nx   = take ? cand : best_q;
  assign idx_nx    = take ? cnt_q : idx_q;
  assign last      = (state_q == S_SCAN) && (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    best_d  = best_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cls_d   = cls_q;
    max_d   = max_q;
    vout_d  = 1'b0;
    ovf_d   = ovf_q;

    if (state_q == S_IDLE) begin
      if (bus.Valid_In) begin
        work_d  = din;
        best_d  = din[0];
        idx_d   = '0;
        cnt_d   = idx_t'(1);
        state_d = S_SCAN;
      end
    end else if (last) begin
      cls_d  = idx_nx;
      max_d  = best_nx;
      vout_d = 1'b1;
      if (pvld_q || bus.Valid_In) begin
        work_d = start_vec;
        best_d = start_vec[0];
        idx_d  = '0;
        cnt_d  = idx_t'(1);
      end else begin
        state_d = S_IDLE;
      end
      // The pending slot frees on this edge, so an arriving vector may refill it.
      if (pvld_q) begin
        pvld_d = bus.Valid_In;
        if (bus.Valid_In) pend_d = din;
      end
    end else begin
      best_d = best_nx;
      idx_d  = idx_nx;
      cnt_d  = cnt_q + idx_t'(1);
      if (bus.Valid_In) begin
        if (!pvld_q) begin
          pend_d = din;
          pvld_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      pend_q  <= '0;
      pvld_q  <= 1'b0;
      best_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      cls_q   <= '0;
      max_q   <= '0;
      vout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      max_q   <= max_d;
      vout_q  <= vout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.Class_Out = cls_q;
  assign bus.Max_Out   = max_q;
  assign bus.Valid_Out = vout_q;
  assign bus.Busy      = (state_q == S_SCAN);
  assign bus.Overflow  = ovf_q;
endmodule
